// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with start/done handshake; shift-add multiplier built when `ALU_MUL_EN` is defined.
// Latency: 1 edge for func 0-6 (and func 7 without ALU_MUL_EN); mul result and done at edge WIDTH after accept.
// Backpressure: busy=1 while a multiply runs; start is ignored (never queued) while busy.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       func,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_hi,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;
  localparam logic [2:0] FN_SHL = 3'd5;
  localparam logic [2:0] FN_SHR = 3'd6;
  localparam logic [2:0] FN_MUL = 3'd7;

  // Result and flag registers, visible directly on the outputs.
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] c_hi_q, c_hi_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  // A request is taken only when no multiply is in flight.
  logic accept;
  assign accept = start && !busy;

  // ---------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             shamt_big;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_zero;

  // The extra top bit of the subtraction is the borrow, i.e. (a < b).
  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} - {1'b0, b};
  // Whole of b is the shift amount; anything >= WIDTH shifts every bit out.
  assign shamt_big = ({1'b0, b} >= (WIDTH+1)'(WIDTH));

  // Combinational result for the single-cycle operations.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (func)
      FN_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
      end
      FN_SUB: begin
        alu_res   = sub_full[WIDTH-1:0];
        alu_carry = sub_full[WIDTH];
      end
      FN_AND:  alu_res = a & b;
      FN_OR:   alu_res = a | b;
      FN_XOR:  alu_res = a ^ b;
      FN_SHL:  alu_res = shamt_big ? '0 : (a << b);
      FN_SHR:  alu_res = shamt_big ? '0 : (a >> b);
      // Without the multiplier func 7 yields a zero result; with it, the
      // single-cycle path is not used for func 7 at all.
      FN_MUL:  alu_res = '0;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

`ifdef ALU_MUL_EN
  // ---------------------------------------------------------------------
  // Shift-add multiplier: one multiplier bit consumed per cycle, LSB first.
  // acc holds the running high word; mplier shifts right and fills from the
  // top with finished product bits, so after WIDTH steps {acc, mplier} is
  // the full double-width product.
  // ---------------------------------------------------------------------
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_mplier;
  logic             mul_fin;

  assign busy = (state_q == S_MUL);

  // One shift-add step: conditionally add the multiplicand, then shift the
  // {carry, acc, mplier} chain right by one.
  always_comb begin
    step_sum    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    step_acc    = step_sum[WIDTH:1];
    step_mplier = {step_sum[0], mplier_q[WIDTH-1:1]};
  end

  // FSM next state: IDLE launches a multiply on an accepted func 7, MUL
  // counts WIDTH steps and flags the final one so the outputs load from it.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    mul_fin  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && (func == FN_MUL)) begin
          state_d  = S_MUL;
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_MUL: begin
        acc_d    = step_acc;
        mplier_d = step_mplier;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_IDLE;
          mul_fin = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier state; reset aborts any multiply in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Output next state: single-cycle ops load at accept, the multiply loads
  // from its last step; otherwise everything holds and done drops.
  always_comb begin
    c_d     = c_q;
    c_hi_d  = c_hi_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    if (mul_fin) begin
      c_d     = step_mplier;
      c_hi_d  = step_acc;
      carry_d = 1'b0;
      zero_d  = ({step_acc, step_mplier} == '0);
      done_d  = 1'b1;
    end else if (accept && (func != FN_MUL)) begin
      c_d     = alu_res;
      c_hi_d  = '0;
      carry_d = alu_carry;
      zero_d  = alu_zero;
      done_d  = 1'b1;
    end
  end
`else
  // No multiplier: every op, func 7 included, completes in one edge.
  assign busy = 1'b0;

  // Output next state: load on every accept, otherwise hold and drop done.
  always_comb begin
    c_d     = c_q;
    c_hi_d  = c_hi_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    if (accept) begin
      c_d     = alu_res;
      c_hi_d  = '0;
      carry_d = alu_carry;
      zero_d  = alu_zero;
      done_d  = 1'b1;
    end
  end
`endif

  // Result/flag registers; done is a one-cycle pulse on each update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q     <= '0;
      c_hi_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      c_q     <= c_d;
      c_hi_q  <= c_hi_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign c     = c_q;
  assign c_hi  = c_hi_q;
  assign carry = carry_q;
  assign zero  = zero_q;
  assign done  = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at WIDTH=8, expected values hand-computed.
// Observed word is {c_hi, c, carry, zero, busy, done}; sampled 1ns after each rising edge.
// Multiplier scenarios run when ALU_MUL_EN is defined, the no-multiplier scenario otherwise.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] func;
  logic [7:0] c;
  logic [7:0] c_hi;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [19:0] obs;
  assign obs = {c_hi, c, carry, zero, busy, done};

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .func  (func),
    .c     (c),
    .c_hi  (c_hi),
    .carry (carry),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge; returns 1ns after that edge.
  task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic [2:0] fi);
    start = 1'b1;
    a     = ai;
    b     = bi;
    func  = fi;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'($urandom);
    b     = 8'($urandom);
    func  = 3'($urandom);
    #3;
    total_cnt++;
    if (obs !== 20'h0) $display("FAIL reset_async got %h exp %h", obs, 20'h0);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (obs !== 20'h0) $display("FAIL reset_held got %h exp %h", obs, 20'h0);
    else pass_cnt++;
    start = 1'b0;
    rst   = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (obs !== 20'h0) $display("FAIL reset_idle got %h exp %h", obs, 20'h0);
    else pass_cnt++;
  endtask

  task automatic test_add();
    issue(8'd10, 8'd3, 3'd0);
    total_cnt++;
    if (obs !== {8'h00, 8'd13, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL add_10_3 got %h exp %h", obs, {8'h00, 8'd13, 4'b0001});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== {8'h00, 8'd13, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL add_hold got %h exp %h", obs, {8'h00, 8'd13, 4'b0000});
    else pass_cnt++;
    issue(8'd200, 8'd100, 3'd0);
    total_cnt++;
    if (obs !== {8'h00, 8'd44, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL add_carry got %h exp %h", obs, {8'h00, 8'd44, 4'b1001});
    else pass_cnt++;
  endtask

  task automatic test_sub();
    issue(8'd4, 8'd2, 3'd1);
    total_cnt++;
    if (obs !== {8'h00, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL sub_4_2 got %h exp %h", obs, {8'h00, 8'd2, 4'b0001});
    else pass_cnt++;
    issue(8'd2, 8'd4, 3'd1);
    total_cnt++;
    if (obs !== {8'h00, 8'd254, 1'b1, 1'b0, 1'b0, 1'b1})
      $display("FAIL sub_borrow got %h exp %h", obs, {8'h00, 8'd254, 4'b1001});
    else pass_cnt++;
    issue(8'd5, 8'd5, 3'd1);
    total_cnt++;
    if (obs !== {8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1})
      $display("FAIL sub_zero got %h exp %h", obs, {8'h00, 8'd0, 4'b0101});
    else pass_cnt++;
  endtask

  task automatic test_logic();
    issue(8'hF0, 8'h3C, 3'd2);
    total_cnt++;
    if (obs !== {8'h00, 8'h30, 4'b0001}) $display("FAIL and got %h exp %h", obs, {8'h00, 8'h30, 4'b0001});
    else pass_cnt++;
    issue(8'hF0, 8'h3C, 3'd3);
    total_cnt++;
    if (obs !== {8'h00, 8'hFC, 4'b0001}) $display("FAIL or got %h exp %h", obs, {8'h00, 8'hFC, 4'b0001});
    else pass_cnt++;
    issue(8'hF0, 8'h3C, 3'd4);
    total_cnt++;
    if (obs !== {8'h00, 8'hCC, 4'b0001}) $display("FAIL xor got %h exp %h", obs, {8'h00, 8'hCC, 4'b0001});
    else pass_cnt++;
  endtask

  task automatic test_shift();
    issue(8'h81, 8'd1, 3'd5);
    total_cnt++;
    if (obs !== {8'h00, 8'h02, 4'b0001}) $display("FAIL shl_1 got %h exp %h", obs, {8'h00, 8'h02, 4'b0001});
    else pass_cnt++;
    issue(8'h81, 8'd1, 3'd6);
    total_cnt++;
    if (obs !== {8'h00, 8'h40, 4'b0001}) $display("FAIL shr_1 got %h exp %h", obs, {8'h00, 8'h40, 4'b0001});
    else pass_cnt++;
    issue(8'h81, 8'd8, 3'd6);
    total_cnt++;
    if (obs !== {8'h00, 8'h00, 4'b0101}) $display("FAIL shr_8 got %h exp %h", obs, {8'h00, 8'h00, 4'b0101});
    else pass_cnt++;
    issue(8'h81, 8'd200, 3'd5);
    total_cnt++;
    if (obs !== {8'h00, 8'h00, 4'b0101}) $display("FAIL shl_200 got %h exp %h", obs, {8'h00, 8'h00, 4'b0101});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    a     = 8'd1;
    b     = 8'd1;
    func  = 3'd0;
    tick();
    total_cnt++;
    if (obs !== {8'h00, 8'd2, 4'b0001}) $display("FAIL b2b_first got %h exp %h", obs, {8'h00, 8'd2, 4'b0001});
    else pass_cnt++;
    a = 8'd3;
    b = 8'd4;
    tick();
    total_cnt++;
    if (obs !== {8'h00, 8'd7, 4'b0001}) $display("FAIL b2b_second got %h exp %h", obs, {8'h00, 8'd7, 4'b0001});
    else pass_cnt++;
    start = 1'b0;
    tick();
    total_cnt++;
    if (obs !== {8'h00, 8'd7, 4'b0000}) $display("FAIL b2b_idle got %h exp %h", obs, {8'h00, 8'd7, 4'b0000});
    else pass_cnt++;
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    int bad;
    issue(8'd200, 8'd3, 3'd7);
    total_cnt++;
    if ({busy, done} !== 2'b10) $display("FAIL mul_accept got busy,done=%b exp 10", {busy, done});
    else pass_cnt++;
    bad = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 3) begin
        start = 1'b1;
        a     = 8'd1;
        b     = 8'd1;
        func  = 3'd0;
      end
      if (k == 4) start = 1'b0;
      tick();
      if ({busy, done} !== 2'b10) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL mul_busy_window got %0d bad cycles exp 0", bad);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== {8'h02, 8'h58, 4'b0001}) $display("FAIL mul_200_3 got %h exp %h", obs, {8'h02, 8'h58, 4'b0001});
    else pass_cnt++;
    // Earliest accept after a multiply: the edge right after busy fell.
    issue(8'd9, 8'd9, 3'd4);
    total_cnt++;
    if (obs !== {8'h00, 8'h00, 4'b0101}) $display("FAIL mul_next_accept got %h exp %h", obs, {8'h00, 8'h00, 4'b0101});
    else pass_cnt++;
    issue(8'd255, 8'd255, 3'd7);
    for (int k = 1; k <= 7; k++) tick();
    tick();
    total_cnt++;
    if (obs !== {8'hFE, 8'h01, 4'b0001}) $display("FAIL mul_255_255 got %h exp %h", obs, {8'hFE, 8'h01, 4'b0001});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (obs !== {8'hFE, 8'h01, 4'b0000}) $display("FAIL mul_hold got %h exp %h", obs, {8'hFE, 8'h01, 4'b0000});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_mul();
    int bad;
    issue(8'd255, 8'd255, 3'd7);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (obs !== 20'h0) $display("FAIL rst_mid_mul got %h exp %h", obs, 20'h0);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL rst_mid_mul_quiet got %0d bad cycles exp 0", bad);
    else pass_cnt++;
    issue(8'd1, 8'd1, 3'd0);
    total_cnt++;
    if (obs !== {8'h00, 8'd2, 4'b0001}) $display("FAIL rst_mid_mul_after got %h exp %h", obs, {8'h00, 8'd2, 4'b0001});
    else pass_cnt++;
  endtask
`else
  task automatic test_nomul();
    int bad;
    issue(8'd3, 8'd3, 3'd7);
    total_cnt++;
    if (obs !== {8'h00, 8'h00, 4'b0101}) $display("FAIL nomul_func7 got %h exp %h", obs, {8'h00, 8'h00, 4'b0101});
    else pass_cnt++;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL nomul_quiet got %0d bad cycles exp 0", bad);
    else pass_cnt++;
    issue(8'd1, 8'd1, 3'd0);
    total_cnt++;
    if (obs !== {8'h00, 8'd2, 4'b0001}) $display("FAIL nomul_after got %h exp %h", obs, {8'h00, 8'd2, 4'b0001});
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_back_to_back();
`ifdef ALU_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_nomul();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit combinational ALU. Takes WIDTH-bit operands with a start/done handshake, registers every result and flag, and adds a multi-cycle shift-add multiplier that returns a double-width product. It sits between operand registers and a result consumer in datapaths where the ALU result must be clocked and the ALU can stall the issuer.

## Interface
- WIDTH, default 8: operand and result word width (minimum 2).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted on a clk edge when busy==0.
- a  input  WIDTH  operand A, sampled at accept.
- b  input  WIDTH  operand B, sampled at accept.
- func  input  3  operation select, sampled at accept.
- c  output  WIDTH  result, low word of the product for mul.
- c_hi  output  WIDTH  high word of the product; 0 for all other ops.
- carry  output  1  carry (add) or borrow (sub); 0 otherwise.
- zero  output  1  1 when c==0, or when {c_hi,c}==0 for mul.
- busy  output  1  multiply in progress.
- done  output  1  one-cycle pulse when c/c_hi/flags update.

## Operation
- func codes: 0 add, 1 sub (a-b), 2 and, 3 or, 4 xor, 5 shl (a<<b), 6 shr (a>>b, logical), 7 mul (unsigned).
- add: {carry,c} = a+b, modulo 2^WIDTH. sub: c = a-b modulo 2^WIDTH; carry = (a<b).
- Shifts: the whole of b is the shift amount; when b>=WIDTH, c=0.
- mul: {c_hi,c} = a*b, 2*WIDTH bits, with no truncation.
- States: IDLE and MUL. IDLE + accepted start with func!=7 stays IDLE and updates the results. IDLE + accepted start with func==7 latches a and b, clears the accumulator and goes to MUL. MUL runs one shift-add step per cycle for WIDTH steps, then returns to IDLE.
- Operands are latched at accept. Changes on a, b, func or start while busy==1 have no effect.
- start while busy==1 is ignored and not queued.
- c, c_hi, carry and zero hold their value until the next done.
- Reset: c=0, c_hi=0, carry=0, zero=0, busy=0, done=0, state IDLE, accumulator and counter cleared. Reset during MUL aborts the multiply with no done pulse.

## Timing
- Single-cycle ops (func 0-6): the accept edge registers the result and flags and sets done=1 for exactly one cycle. Latency is 1 edge. busy stays 0, so back-to-back starts on consecutive edges are accepted, with done high on each following cycle.
- mul: busy rises at the accept edge (edge 0). Shift-add steps run on edges 1..WIDTH. At edge WIDTH, busy falls, done=1 for one cycle, and c, c_hi and zero become valid.
- The earliest new accept after a mul is the edge after busy falls.
- done and busy are never both 1.

## Configuration
- ALU_MUL_EN defined: the multiplier, the MUL state and the busy behaviour are built as described.
- ALU_MUL_EN undefined: no multiplier logic. func 7 completes like a single-cycle op with c=0, c_hi=0, carry=0, zero=1. busy is tied to 0.

## Test plan
- Reset: assert rst with random inputs -> c=0, c_hi=0, carry=0, zero=0, busy=0, done=0. Deassert, idle 2 cycles -> all outputs remain 0.
- Add (WIDTH=8):
  - a=10, b=3, func=0, start -> next cycle c=13, carry=0, done pulses once.
  - a=200, b=100 -> c=44, carry=1.
- Sub:
  - a=4, b=2, func=1 -> c=2, carry=0.
  - a=2, b=4 -> c=254, carry=1.
  - a=5, b=5 -> c=0, zero=1.
- Multiply with ALU_MUL_EN:
  - a=200, b=3, func=7, start -> busy high for 8 cycles, then done with c=0x58, c_hi=0x02, zero=0.
  - A start pulse with a=1 mid-busy is ignored: no extra done, and the product is unchanged.
- Reset mid-multiply: accept a=255, b=255, func=7, then assert rst after 3 cycles -> busy=0, no done, outputs 0. After release, a=1, b=1, func=0 -> c=2, done.
- Shifts and no-mul build:
  - a=0x81, b=1, func=5 -> c=0x02.
  - a=0x81, b=8, func=6 -> c=0, zero=1.
  - Without ALU_MUL_EN: func=7, a=3, b=3 -> one-cycle done, c=0, c_hi=0, zero=1, busy never 1.
